// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM demodulator returning the duty word of a 2**WIDTH-clock PWM stream
//
// Purpose: synchronises a 1-bit PWM stream, counts its high samples over
// consecutive 2**WIDTH-clock windows and reports the duty word plus
// full-scale and stuck-level flags. Any 2**WIDTH-cycle window of a periodic
// stream holds exactly the high time, so no phase lock to the generator is
// needed.
//
// Optional feature: define PWM_CAPTURE_AVG_EN to average four consecutive
// windows before reporting (one strobe every 4 windows).
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low; clears all state
//   en          1 = measure; 0 = hold outputs and clear the window
//   pwm_in      PWM stream, may be asynchronous to clk
//   duty_out    measured high cycles per window, saturated to all-ones
//   duty_valid  one-cycle strobe: duty_out and flags updated this cycle
//   duty_full   input high for every sample of the reported window(s)
//   stuck_hi    no edge in the last window, level high
//   stuck_lo    no edge in the last window, level low
module pwm_capture #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_out,
  output logic             duty_valid,
  output logic             duty_full,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_prev;
  logic                   pwm_edge;
  logic [WIDTH-1:0]       wcnt;
  logic [WIDTH:0]         hcnt;
  logic [WIDTH:0]         hcnt_final;
  logic                   saw_edge;
  logic                   edge_final;
  logic                   win_end;

  // Result of the current measurement, applied to the outputs when res_valid.
  logic                   res_valid;
  logic [WIDTH:0]         res_cnt;
  logic                   res_full;

  assign s          = sync_q[SYNC_STAGES-1];
  assign pwm_edge   = s ^ s_prev;
  assign win_end    = en && (wcnt == {WIDTH{1'b1}});
  // The sample taken in the last cycle of the window still belongs to it.
  assign hcnt_final = hcnt + {{WIDTH{1'b0}}, s};
  assign edge_final = saw_edge | pwm_edge;

  // The synchroniser keeps running while en=0 so a fresh window starts
  // with a settled sample history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_prev <= s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt     <= '0;
      hcnt     <= '0;
      saw_edge <= 1'b0;
    end else if (!en) begin
      wcnt     <= '0;
      hcnt     <= '0;
      saw_edge <= 1'b0;
    end else begin
      wcnt <= wcnt + WIDTH'(1);
      if (win_end) begin
        hcnt     <= '0;
        saw_edge <= 1'b0;
      end else begin
        hcnt     <= hcnt_final;
        saw_edge <= edge_final;
      end
    end
  end

`ifdef PWM_CAPTURE_AVG_EN
  logic [1:0]       acnt;
  logic [WIDTH+2:0] acc;
  logic [WIDTH+2:0] acc_sum;
  logic             any_short;

  assign acc_sum = acc + {2'b00, hcnt_final};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acnt      <= '0;
      acc       <= '0;
      any_short <= 1'b0;
    end else if (!en) begin
      acnt      <= '0;
      acc       <= '0;
      any_short <= 1'b0;
    end else if (win_end) begin
      if (acnt == 2'd3) begin
        acnt      <= '0;
        acc       <= '0;
        any_short <= 1'b0;
      end else begin
        acnt      <= acnt + 2'd1;
        acc       <= acc_sum;
        any_short <= any_short | ~hcnt_final[WIDTH];
      end
    end
  end

  // Sum of four windows divided by four, truncating; max is exactly 2**WIDTH.
  always_comb begin
    res_valid = win_end && (acnt == 2'd3);
    res_cnt   = acc_sum[WIDTH+2:2];
    res_full  = !any_short && hcnt_final[WIDTH];
  end
`else
  always_comb begin
    res_valid = win_end;
    res_cnt   = hcnt_final;
    res_full  = hcnt_final[WIDTH];
  end
`endif

  // Stuck flags always describe the window that just closed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_out   <= '0;
      duty_valid <= 1'b0;
      duty_full  <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
    end else begin
      duty_valid <= res_valid;
      if (res_valid) begin
        duty_out  <= res_cnt[WIDTH] ? {WIDTH{1'b1}} : res_cnt[WIDTH-1:0];
        duty_full <= res_full;
        stuck_hi  <= !edge_final && s;
        stuck_lo  <= !edge_final && !s;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture against a window-sum reference model
module tb_pwm_capture;

  localparam int W    = 5;
  localparam int SYNC = 2;
  localparam int WIN  = 1 << W;
`ifdef PWM_CAPTURE_AVG_EN
  localparam int NAVG = 4;
`else
  localparam int NAVG = 1;
`endif
  localparam int PER  = WIN * NAVG;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic         en     = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] duty_out;
  logic         duty_valid;
  logic         duty_full;
  logic         stuck_hi;
  logic         stuck_lo;

  int checks   = 0;
  int failures = 0;

  pwm_capture #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .duty_valid (duty_valid),
    .duty_full  (duty_full),
    .stuck_hi   (stuck_hi),
    .stuck_lo   (stuck_lo)
  );

  always #5 clk = ~clk;

  // Reference model: pwm_in history per rising edge; a window result is the
  // plain sum of the delayed samples over the last WIN enabled edges.
  bit ph[$];
  int mark   = 0;
  int en_run = 0;
  int e_duty = 0;
  bit e_valid = 0, e_full = 0, e_sh = 0, e_sl = 0;

  // Stimulus generator: 0 constant level, 1 periodic PWM, 2 random bits.
  int gmode = 0;
  int gref  = 0;
  int gcnt  = 0;

  function automatic bit smp(int k);
    if (k - SYNC < mark) return 1'b0;
    return ph[k-SYNC];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int k, tot, ws, nfull;
    bit edg;
    ph.push_back(pwm_in);
    k = ph.size() - 1;
    e_valid = 1'b0;
    if (!reset) begin
      mark = k + 1; en_run = 0;
      e_duty = 0; e_full = 0; e_sh = 0; e_sl = 0;
      return;
    end
    if (!en) begin
      en_run = 0;
      return;
    end
    en_run++;
    if (en_run % PER != 0) return;
    tot = 0; nfull = 0; edg = 1'b0;
    for (int w = 0; w < NAVG; w++) begin
      ws = 0;
      for (int j = k - WIN*(w+1) + 1; j <= k - WIN*w; j++) ws += int'(smp(j));
      tot += ws;
      if (ws == WIN) nfull++;
    end
    for (int j = k - WIN + 1; j <= k; j++) if (smp(j) != smp(j-1)) edg = 1'b1;
    e_valid = 1'b1;
    e_duty  = (tot / NAVG > WIN - 1) ? WIN - 1 : tot / NAVG;
    e_full  = (nfull == NAVG);
    e_sh    = !edg && smp(k);
    e_sl    = !edg && !smp(k);
  endtask

  task automatic gen_next();
    case (gmode)
      0: pwm_in = gref[0];
      1: begin gcnt = (gcnt + 1) % WIN; pwm_in = (gcnt < gref); end
      default: pwm_in = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("cyc_valid", duty_valid, e_valid);
    chk("cyc_duty",  duty_out,   e_duty);
    chk("cyc_full",  duty_full,  e_full);
    chk("cyc_sthi",  stuck_hi,   e_sh);
    chk("cyc_stlo",  stuck_lo,   e_sl);
    gen_next();
  endtask

  task automatic wait_strobe(input int limit, output int n);
    n = 0;
    do begin tick(); n++; end while (!duty_valid && n < limit);
    chk("strobe_seen", duty_valid, 1);
  endtask

  task automatic check_flags(input string tag, input int d, input bit f, input bit h, input bit l);
    chk({tag, "_duty"}, duty_out, d);
    chk({tag, "_full"}, duty_full, f);
    chk({tag, "_sthi"}, stuck_hi, h);
    chk({tag, "_stlo"}, stuck_lo, l);
  endtask

  int n;
  int offs[3] = '{0, 7, 31};
  int avg_refs[8] = '{8, 16, 8, 16, 8, 8, 8, 9};

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_valid", duty_valid, 0);
    check_flags("rst", 0, 0, 0, 0);
    #1 reset = 1'b1;

    // Reference ref=10: first strobe latency, period, value
    gmode = 1; gref = 10;
    repeat (4) tick();
    en = 1'b1;
    wait_strobe(PER + 8, n);
    chk("first_lat", n, PER);
    check_flags("ref10a", 10, 0, 0, 0);
    wait_strobe(PER + 8, n);
    chk("period", n, PER);
    check_flags("ref10b", 10, 0, 0, 0);

    // en dropped at wcnt=12 for 5 clocks: no strobe, outputs held
    repeat (12) tick();
    en = 1'b0;
    repeat (5) begin
      tick();
      chk("gap_valid", duty_valid, 0);
      chk("gap_hold", duty_out, 10);
    end
    en = 1'b1;
    wait_strobe(PER + 8, n);
    chk("restart_lat", n, PER);
    chk("restart_duty", duty_out, 10);

    // Reset mid-window clears outputs immediately
    repeat (7) tick();
    reset = 1'b0;
    #1;
    chk("mrst_valid", duty_valid, 0);
    check_flags("mrst", 0, 0, 0, 0);
    repeat (2) tick();
    reset = 1'b1;
    wait_strobe(PER + 8, n);
    chk("mrst_lat", n, PER);

    // Phase offsets between stream and en rise
    foreach (offs[i]) begin
      en = 1'b0;
      gcnt = (offs[i] + WIN - 3) % WIN;
      repeat (3) tick();
      en = 1'b1;
      wait_strobe(PER + 8, n);
      chk("phase_lat", n, PER);
      check_flags("phase", 10, 0, 0, 0);
    end

    // Constant low
    en = 1'b0; gmode = 0; gref = 0; pwm_in = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    wait_strobe(PER + 8, n);
    check_flags("const0", 0, 0, 0, 1);

    // Constant high
    en = 1'b0; gref = 1; pwm_in = 1'b1;
    repeat (3) tick();
    en = 1'b1;
    wait_strobe(PER + 8, n);
    check_flags("const1", WIN - 1, 1, 1, 0);

    // ref=31: saturated value without the full flag
    gmode = 1; gref = 31;
    wait_strobe(PER + 8, n);
    wait_strobe(PER + 8, n);
    check_flags("ref31", WIN - 1, 0, 0, 0);

`ifdef PWM_CAPTURE_AVG_EN
    // Window boundaries land in the low part of every pattern used here
    en = 1'b0; gref = avg_refs[0];
    for (int i = 0; i < WIN && gcnt != 25; i++) tick();
    en = 1'b1;
    foreach (avg_refs[i]) begin
      if (i > 0) gref = avg_refs[i];
      repeat (WIN) tick();
      if (i == 3) begin
        chk("avg_strobe1", duty_valid, 1);
        chk("avg_duty1", duty_out, 12);
      end
      if (i == 7) begin
        chk("avg_strobe2", duty_valid, 1);
        chk("avg_duty2", duty_out, 8);
      end
    end
`endif

    // Random periodic references
    repeat (4) begin
      gref = $urandom_range(0, WIN - 1);
      repeat (2 * PER + 5) tick();
    end

    // Random bit stream with random en toggling
    gmode = 2;
    repeat (1500) begin
      if ($urandom_range(0, 99) < 2) en = ~en;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
